// File: rtl/conv_sequencer.sv
// -----------------------------------------------------------------------------
// conv_sequencer
//
// Control sequencer for the convolution accelerator. For each of N_OUT outputs
// it reads LOAD_CYCLES words from the input RAM and filter ROM, runs the
// multiply phase, walks the ADD_LEVELS-deep adder tree and then writes one
// result into the result FIFO, honouring FIFO backpressure. A run is started
// by a start pulse in IDLE and ends with a one-cycle done pulse. abort (or
// reset) cancels a run at any point.
//
// Optional feature: define CONV_SEQ_STALL_CNT_EN to build the saturating
// backpressure counter on stall_cnt; otherwise stall_cnt is tied to zero.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   start      run request, honoured only in IDLE
//   abort      synchronous run cancel, ignored in IDLE
//   fifo_full  result FIFO full (backpressure)
//   busy       high in every non-IDLE state
//   done       one-cycle completion pulse (first IDLE cycle after the run)
//   ram_en     input RAM read enable (LOAD only)
//   ram_addr   input RAM read address (LOAD only, else 0)
//   rom_en     filter ROM read enable (LOAD only)
//   rom_addr   filter ROM read address (LOAD only, else 0)
//   dp_ctrl    one-hot phase select: [ADD_LEVELS] = multiply,
//              [ADD_LEVELS-1-k] = adder level k
//   fifo_wr    result FIFO write strobe
//   stall_cnt  count of STORE cycles blocked by fifo_full
// -----------------------------------------------------------------------------
module conv_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int ROM_AW      = 1,
    parameter int N_OUT       = 256,
    parameter int LOAD_CYCLES = 2,
    parameter int MULT_CYCLES = 16,
    parameter int ADD_LEVELS  = 4,
    parameter int ADD_CYCLES  = 8,
    parameter int IN_STRIDE   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic                  done,
    output logic                  ram_en,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  rom_en,
    output logic [ROM_AW-1:0]     rom_addr,
    output logic [ADD_LEVELS:0]   dp_ctrl,
    output logic                  fifo_wr,
    output logic [15:0]           stall_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_MULT  = 3'd2;
    localparam logic [2:0] S_ADD   = 3'd3;
    localparam logic [2:0] S_STORE = 3'd4;

    // One phase counter serves LOAD, MULT and every adder level, so it is
    // sized for the longest of them.
    localparam int MAX_LM = (LOAD_CYCLES > MULT_CYCLES) ? LOAD_CYCLES : MULT_CYCLES;
    localparam int MAX_PH = (MAX_LM > ADD_CYCLES) ? MAX_LM : ADD_CYCLES;
    localparam int CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
    localparam int LVL_W  = 3;

    logic [2:0]            state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [LVL_W-1:0]      lvl, lvl_n;
    logic [15:0]           oidx, oidx_n;
    logic                  done_n;
    logic                  store_q;
    logic [ADDR_W-1:0]     ram_addr_n;
    logic [ROM_AW-1:0]     rom_addr_n;
    logic [ADD_LEVELS:0]   dp_n;

    // Next-state and next-counter logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would infer a latch.
        state_n = state;
        cnt_n   = cnt;
        lvl_n   = lvl;
        oidx_n  = oidx;
        done_n  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_LOAD;
                    cnt_n   = '0;
                    lvl_n   = '0;
                    oidx_n  = '0;
                end
            end
            S_LOAD: begin
                if (cnt == CNT_W'(LOAD_CYCLES - 1)) begin
                    state_n = S_MULT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_MULT: begin
                if (cnt == CNT_W'(MULT_CYCLES - 1)) begin
                    state_n = S_ADD;
                    cnt_n   = '0;
                    lvl_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_ADD: begin
                if (cnt == CNT_W'(ADD_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (lvl == LVL_W'(ADD_LEVELS - 1)) begin
                        state_n = S_STORE;
                        lvl_n   = '0;
                    end else begin
                        lvl_n = lvl + LVL_W'(1);
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_STORE: begin
                if (!fifo_full) begin
                    cnt_n = '0;
                    if (oidx == 16'(N_OUT - 1)) begin
                        state_n = S_IDLE;
                        oidx_n  = '0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_LOAD;
                        oidx_n  = oidx + 16'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                lvl_n   = '0;
                oidx_n  = '0;
            end
        endcase

        // abort outranks every other transition, including the final write.
        if (abort && state != S_IDLE) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            lvl_n   = '0;
            oidx_n  = '0;
            done_n  = 1'b0;
        end
    end

    // Outputs are computed from the next state so that, once registered,
    // they line up with the cycle in which that state is occupied.
    always_comb begin
        ram_addr_n = '0;
        rom_addr_n = '0;
        dp_n       = '0;
        if (state_n == S_LOAD) begin
            ram_addr_n = ADDR_W'(32'(oidx_n) * 32'(IN_STRIDE) + 32'(cnt_n));
            rom_addr_n = ROM_AW'(cnt_n);
        end
        if (state_n == S_MULT) begin
            dp_n[ADD_LEVELS] = 1'b1;
        end
        if (state_n == S_ADD) begin
            for (int k = 0; k < ADD_LEVELS; k++) begin
                if (lvl_n == LVL_W'(k)) begin
                    dp_n[ADD_LEVELS-1-k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            lvl      <= '0;
            oidx     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ram_en   <= 1'b0;
            ram_addr <= '0;
            rom_en   <= 1'b0;
            rom_addr <= '0;
            dp_ctrl  <= '0;
            store_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            state    <= state_n;
            cnt      <= cnt_n;
            lvl      <= lvl_n;
            oidx     <= oidx_n;
            busy     <= (state_n != S_IDLE);
            done     <= done_n;
            ram_en   <= (state_n == S_LOAD);
            ram_addr <= ram_addr_n;
            rom_en   <= (state_n == S_LOAD);
            rom_addr <= rom_addr_n;
            dp_ctrl  <= dp_n;
            store_q  <= (state_n == S_STORE);
        end
    end

    // The write must land in the very STORE cycle where fifo_full is low, so
    // the strobe is a registered STORE flag qualified by the live inputs;
    // abort and reset suppress the write in the cycle they are asserted.
    assign fifo_wr = store_q & ~fifo_full & ~abort & reset;

`ifdef CONV_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == S_STORE && fifo_full && !abort && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule
